pixel_write_combiner: RTL and testbench
=======================================

PIXEL_WRITE_COMBINER -- requirements
Module: pixel_write_combiner

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of completed-word slots (power of two, >=2).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 16, cycles without a new pixel before the open word is flushed.
REQ-003 SHALL have port clk, input, 1, master clock; one clock only, all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port de_req, input, 1, pixel write request from the drawing engine; held until de_ack.
REQ-006 SHALL have port de_ack, output, 1, pixel accepted this cycle (combinational: de_req && ready).
REQ-007 SHALL have port de_addr, input, 18, frame-store word address of the pixel.
REQ-008 SHALL have port de_nbyte, input, 4, active-low byte enables; bit i low = lane i written.
REQ-009 SHALL have port de_data, input, 32, pixel data; lane i = bits 8i+7:8i.
REQ-010 SHALL have port drawing_busy, input, 1, drawing engine busy; low = no further pixels expected.
REQ-011 SHALL have port fs_req, output, 1, frame-store write request; high while the FIFO is non-empty.
REQ-012 SHALL have port fs_ack, input, 1, frame store consumed the head word; single-cycle pulse.
REQ-013 SHALL have port fs_addr, output, 18, head word address.
REQ-014 SHALL have port fs_nbyte, output, 4, head word active-low byte enables.
REQ-015 SHALL have port fs_data, output, 32, head word data.
REQ-016 SHALL have port idle, output, 1, high when there is no open word and the FIFO is empty.

Function
REQ-017 SHALL hold one open word (valid, addr, nbyte, data) and a FIFO of FIFO_DEPTH completed words.
REQ-018 SHALL use FSM states EMPTY (no open word), OPEN (open word collecting) and EVICT (open word must leave, FIFO full).
REQ-019 SHALL, in EMPTY on accept, load the open word: addr=de_addr, nbyte=de_nbyte, lanes with enable low from de_data, others 0; go to OPEN.
REQ-020 SHALL, in OPEN on accept with de_addr equal to the open addr, merge: nbyte&=de_nbyte, enabled lanes overwritten; a later pixel wins per lane.
REQ-021 SHALL, in OPEN on de_req with a different addr, push the open word to the FIFO and load the new pixel as the open word in the same cycle; if the FIFO is full and not popping, deassert de_ack and go to EVICT.
REQ-022 SHALL, when the merged nbyte becomes 4'b0000, push the word into the FIFO on the next edge (state EMPTY); if the FIFO is full, hold in EVICT.
REQ-023 SHALL flush the open word when drawing_busy is low and no pixel is accepted, or when the idle counter reaches IDLE_TIMEOUT; the counter resets on every accept.
REQ-024 SHALL, in EVICT, hold de_ack low; push on the first cycle a slot is free, then return to EMPTY.
REQ-025 SHALL treat "full with fs_ack this cycle" as not full: simultaneous pop and push allowed.
REQ-026 SHALL drive fs_addr/fs_nbyte/fs_data from the FIFO head, stable while fs_req is high; fs_ack while fs_req is low is ignored.
REQ-027 SHALL make a pushed word visible on fs_req in the cycle after the push edge (one-cycle latency).
REQ-028 SHALL use pointer wrap-around modulo FIFO_DEPTH and keep an occupancy count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-029 SHALL on rst_n low: state EMPTY, FIFO empty, open word invalid, idle counter 0, de_ack 0, fs_req 0, idle 1, fs_addr/fs_nbyte/fs_data 0/4'b1111/0.
REQ-030 SHALL discard all pending pixels on reset mid-operation, with no partial fs write afterwards.

Structure
REQ-031 SHALL place the state encoding, the frame-store address width (18), data width (32) and lane count (4) in shared package mandelbrot_pkg.
REQ-032 SHALL implement the FIFO as sub-module word_fifo (parameterised depth and width, push/pop/full/empty).

Verification
REQ-033 SHALL cover: four pixels at addr 0x00010, nbyte 1110/1101/1011/0111, data bytes 11/22/33/44 -> one fs write addr 0x00010, nbyte 0000, data 0x44332211.
REQ-034 SHALL cover: pixels at 0x00010 lane 0 then 0x00011 lane 0 -> fs write 0x00010 nbyte 1110; 0x00011 stays open.
REQ-035 SHALL cover: fs_ack held low, 5 full words pushed (depth 4) -> fifth held in EVICT, de_ack low; one fs_ack -> fifth pushed.
REQ-036 SHALL cover: one pixel, drawing_busy high, no more de_req -> flushed after 16 cycles; with drawing_busy low -> flushed next cycle.
REQ-037 SHALL cover: rst_n pulsed low with 2 words queued and one open -> fs_req 0, idle 1, and no fs write after release.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and widths for the pixel write path into the frame store.
package mandelbrot_pkg;

  localparam int unsigned FS_ADDR_W = 18;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LANES     = 4;

  // Combiner FSM states: no open word, open word collecting, open word waiting for a FIFO slot.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_OPEN  = 2'd1,
    ST_EVICT = 2'd2
  } comb_state_t;

  // One frame-store word; nbyte is active-low per 8-bit lane.
  typedef struct packed {
    logic [FS_ADDR_W-1:0] addr;
    logic [LANES-1:0]     nbyte;
    logic [DATA_W-1:0]    data;
  } fs_word_t;

  // Overwrite every lane of base whose enable in nbyte is low with the same lane of upd.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] base,
                                                    input logic [DATA_W-1:0] upd,
                                                    input logic [LANES-1:0]  nbyte);
    logic [DATA_W-1:0] r;
    r = base;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!nbyte[i]) r[8*i +: 8] = upd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of completed words; power-of-two depth, wrapping pointers.
module word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so full-and-popping still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_combiner.sv
// Gathers byte-lane pixel writes to the same frame-store word into one open word,
// then queues completed words for the frame store.
module pixel_write_combiner
  import mandelbrot_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 de_req,
  output logic                 de_ack,
  input  logic [FS_ADDR_W-1:0] de_addr,
  input  logic [LANES-1:0]     de_nbyte,
  input  logic [DATA_W-1:0]    de_data,
  input  logic                 drawing_busy,
  output logic                 fs_req,
  input  logic                 fs_ack,
  output logic [FS_ADDR_W-1:0] fs_addr,
  output logic [LANES-1:0]     fs_nbyte,
  output logic [DATA_W-1:0]    fs_data,
  output logic                 idle
);

  localparam int unsigned CNT_W = $clog2(IDLE_TIMEOUT + 1);

  comb_state_t      state_q, state_d;
  fs_word_t         ow_q, ow_d;
  fs_word_t         load_word;
  fs_word_t         head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idle_next;
  logic             ready;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             full_eff;

  assign load_word = '{addr: de_addr, nbyte: de_nbyte, data: merge_lanes('0, de_data, de_nbyte)};
  assign pop       = fs_ack && !fifo_empty;
  assign full_eff  = fifo_full && !pop;
  assign idle_next = cnt_q + CNT_W'(1);

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fs_word_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ow_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, open-word update, idle counting and the push strobe.
  // A completed open word always leaves before any further pixel is considered,
  // so a completing pixel never merges with a following one.
  always_comb begin
    state_d = state_q;
    ow_d    = ow_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        ready = 1'b1;
        if (de_req) begin
          ow_d    = load_word;
          cnt_d   = '0;
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (ow_q.nbyte == '0) begin
          if (full_eff) begin
            state_d = ST_EVICT;
          end else begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_EMPTY;
          end
        end else if (de_req && (de_addr == ow_q.addr)) begin
          ready      = 1'b1;
          ow_d.nbyte = ow_q.nbyte & de_nbyte;
          ow_d.data  = merge_lanes(ow_q.data, de_data, de_nbyte);
          cnt_d      = '0;
        end else if (de_req) begin
          if (full_eff) begin
            state_d = ST_EVICT;
          end else begin
            ready = 1'b1;
            push  = 1'b1;
            ow_d  = load_word;
            cnt_d = '0;
          end
        end else if (!drawing_busy || (idle_next == CNT_W'(IDLE_TIMEOUT))) begin
          if (full_eff) begin
            state_d = ST_EVICT;
          end else begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_EMPTY;
          end
        end else begin
          cnt_d = idle_next;
        end
      end
      ST_EVICT: begin
        if (!full_eff) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, open word and idle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ow_q    <= '{addr: '0, nbyte: '1, data: '0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ow_q    <= ow_d;
      cnt_q   <= cnt_d;
    end
  end

  // No handshake completes while held in reset.
  assign de_ack   = de_req && ready && rst_n;
  assign fs_req   = !fifo_empty;
  assign fs_addr  = fs_req ? head.addr  : '0;
  assign fs_nbyte = fs_req ? head.nbyte : '1;
  assign fs_data  = fs_req ? head.data  : '0;
  assign idle     = (state_q == ST_EMPTY) && fifo_empty;

endmodule

// File: tb/tb_pixel_write_combiner.sv
// Scoreboard bench for pixel_write_combiner: stimulus pushes expected frame-store
// words, a negedge monitor acks writes and compares them in order.
module tb_pixel_write_combiner;

  localparam int IDLE_TO = 16;

  typedef struct {
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_data;
  logic        drawing_busy;
  logic        fs_req;
  logic        fs_ack;
  logic [17:0] fs_addr;
  logic [3:0]  fs_nbyte;
  logic [31:0] fs_data;
  logic        idle;

  int   vectors = 0;
  int   miscompares = 0;
  int   ack_mode = 0;   // 0 never, 1 random, 2 always
  int   ack_count = 0;
  exp_t exp_q[$];

  // Reference word builder: consecutive same-address pixels merge per lane,
  // a word closes on address change, full lane coverage, or a flush.
  bit          m_valid = 0;
  logic [17:0] m_addr;
  logic [3:0]  m_nbyte;
  logic [31:0] m_data;

  pixel_write_combiner #(.FIFO_DEPTH(4), .IDLE_TIMEOUT(IDLE_TO)) dut (
    .clk(clk), .rst_n(rst_n), .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr),
    .de_nbyte(de_nbyte), .de_data(de_data), .drawing_busy(drawing_busy), .fs_req(fs_req),
    .fs_ack(fs_ack), .fs_addr(fs_addr), .fs_nbyte(fs_nbyte), .fs_data(fs_data), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [17:0] a, input logic [3:0] n, input logic [31:0] d);
    exp_t e;
    e.addr = a; e.nbyte = n; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic model_flush();
    if (m_valid) expect_word(m_addr, m_nbyte, m_data);
    m_valid = 0;
  endtask

  task automatic model_pixel(input logic [17:0] a, input logic [3:0] n, input logic [31:0] d);
    if (m_valid && m_addr != a) model_flush();
    if (!m_valid) begin
      m_valid = 1; m_addr = a; m_nbyte = 4'hF; m_data = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if (!n[i]) begin
        m_data[8*i +: 8] = d[8*i +: 8];
        m_nbyte[i] = 1'b0;
      end
    end
    if (m_nbyte == 4'h0) model_flush();
  endtask

  // Samples de_ack mid-cycle; called and returns at posedge+1.
  task automatic wait_ack(output bit acc, input int budget);
    int c;
    acc = 0; c = 0;
    while (!acc && c < budget) begin
      #7;
      acc = de_ack;
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic send_pixel(input logic [17:0] a, input logic [3:0] n, input logic [31:0] d);
    bit acc;
    de_req = 1; de_addr = a; de_nbyte = n; de_data = d;
    wait_ack(acc, 2000);
    de_req = 0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || !idle) && c < 3000) begin
      tick();
      c++;
    end
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(idle), 64'd1);
  endtask

  // Monitor: decides the ack at negedge and checks the head word it consumes.
  always @(negedge clk) begin : monitor
    bit   do_ack;
    exp_t e;
    do_ack = 0;
    if (rst_n && fs_req) begin
      case (ack_mode)
        1:       do_ack = ($urandom_range(0, 1) == 1);
        2:       do_ack = 1;
        default: do_ack = 0;
      endcase
    end
    if (do_ack) begin
      ack_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_fs_write: got addr 0x%0h nbyte 0x%0h data 0x%0h, want none",
                 fs_addr, fs_nbyte, fs_data);
      end else begin
        e = exp_q.pop_front();
        check("fs_word", {10'd0, fs_addr, fs_nbyte, fs_data}, {10'd0, e.addr, e.nbyte, e.data});
      end
    end
    fs_ack = do_ack;
  end

  initial begin : stim
    bit          acc;
    int          n, seen, base, c, r;
    logic [17:0] a;
    logic [3:0]  nb;
    logic [31:0] d;

    fs_ack = 0; rst_n = 0; de_req = 0; de_addr = '0; de_nbyte = 4'hF; de_data = '0;
    drawing_busy = 1;
    repeat (3) tick();
    check("reset_fs_req", 64'(fs_req), 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_de_ack", 64'(de_ack), 64'd0);
    check("reset_fs_addr", 64'(fs_addr), 64'd0);
    check("reset_fs_nbyte", 64'(fs_nbyte), 64'hF);
    check("reset_fs_data", 64'(fs_data), 64'd0);
    rst_n = 1;
    tick();

    // Four lanes of one word combine into a single complete write.
    ack_mode = 1;
    expect_word(18'h00010, 4'b0000, 32'h44332211);
    send_pixel(18'h00010, 4'b1110, 32'h11111111);
    send_pixel(18'h00010, 4'b1101, 32'h22222222);
    send_pixel(18'h00010, 4'b1011, 32'h33333333);
    send_pixel(18'h00010, 4'b0111, 32'h44444444);
    wait_drain("merge4");

    // Address change retires the open word; the new pixel stays open.
    ack_mode = 2;
    expect_word(18'h00010, 4'b1110, 32'h000000AA);
    expect_word(18'h00011, 4'b1110, 32'h000000BB);
    send_pixel(18'h00010, 4'b1110, 32'h555555AA);
    send_pixel(18'h00011, 4'b1110, 32'h666666BB);
    repeat (3) tick();
    check("addr_change_one_written", 64'(exp_q.size()), 64'd1);
    check("addr_change_still_open", 64'(idle), 64'd0);
    drawing_busy = 0;
    wait_drain("addr_change");
    drawing_busy = 1;

    // Idle-timeout flush latency with the engine busy.
    expect_word(18'h00030, 4'b1110, 32'h000000AB);
    send_pixel(18'h00030, 4'b1110, 32'h777777AB);
    n = 0; seen = 0;
    while (!seen && n < 40) begin tick(); n++; seen = fs_req; end
    check("timeout_flush_cycles", 64'(n), 64'(IDLE_TO));
    wait_drain("timeout");

    // Flush on the cycle after drawing_busy falls.
    expect_word(18'h00031, 4'b0111, 32'hCD000000);
    send_pixel(18'h00031, 4'b0111, 32'hCD888888);
    drawing_busy = 0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin tick(); n++; seen = fs_req; end
    check("notbusy_flush_cycles", 64'(n), 64'd1);
    wait_drain("notbusy");
    drawing_busy = 1;

    // FIFO full: fifth complete word waits in EVICT, one pop lets it in.
    ack_mode = 0;
    for (int i = 0; i < 6; i++) expect_word(18'h00100 + 18'(i), 4'b0000, 32'hA0000000 + 32'(i));
    for (int i = 0; i < 5; i++) send_pixel(18'h00100 + 18'(i), 4'b0000, 32'hA0000000 + 32'(i));
    repeat (2) tick();
    check("full_fs_req", 64'(fs_req), 64'd1);
    check("full_not_idle", 64'(idle), 64'd0);
    de_req = 1; de_addr = 18'h00105; de_nbyte = 4'b0000; de_data = 32'hA0000005;
    wait_ack(acc, 4);
    check("evict_holds_de_ack", 64'(acc), 64'd0);
    base = ack_count; ack_mode = 2; c = 0;
    while (ack_count == base && c < 10) begin tick(); c++; end
    ack_mode = 0;
    check("single_pop_done", 64'(ack_count - base), 64'd1);
    wait_ack(acc, 10);
    de_req = 0;
    check("accept_after_pop", 64'(acc), 64'd1);
    check("fifo_refilled", 64'(fs_req), 64'd1);
    ack_mode = 1;
    wait_drain("evict");

    // Randomized pixels against the reference word builder.
    for (int k = 0; k < 250; k++) begin
      a  = 18'h00020 + 18'($urandom_range(0, 2));
      nb = 4'($urandom_range(0, 14));
      d  = $urandom;
      model_pixel(a, nb, d);
      send_pixel(a, nb, d);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        model_flush();
        repeat (20) tick();
      end else begin
        repeat (r % 4) tick();
      end
    end
    drawing_busy = 0;
    model_flush();
    wait_drain("random");
    drawing_busy = 1;

    // Reset with two queued words and one open word discards everything.
    ack_mode = 0;
    send_pixel(18'h00200, 4'b0000, 32'h12345678);
    send_pixel(18'h00201, 4'b0000, 32'h9ABCDEF0);
    send_pixel(18'h00202, 4'b1110, 32'h000000EE);
    repeat (3) tick();
    check("prereset_fs_req", 64'(fs_req), 64'd1);
    rst_n = 0;
    #1;
    check("midreset_fs_req", 64'(fs_req), 64'd0);
    check("midreset_idle", 64'(idle), 64'd1);
    repeat (2) tick();
    rst_n = 1;
    ack_mode = 2;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) drawing_busy = 0;
      tick();
      if (fs_req) seen++;
    end
    check("postreset_no_write", 64'(seen), 64'd0);
    check("postreset_idle", 64'(idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
